// File: rtl/fp_stream_pkg.sv
// Shared definitions for the stb/ack floating-point operand stream:
// issuer state encodings, default data width and the handshake helper.
package fp_stream_pkg;

  localparam int unsigned DEFAULT_DATA_W = 32;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEND   = 2'd1;
  localparam logic [1:0] ST_WAIT_Z = 2'd2;

  // A word moves on any edge where the strobe and its ack are both high.
  function automatic logic xfer(input logic stb, input logic ack);
    return stb & ack;
  endfunction

endpackage

// File: rtl/stb_watchdog.sv
// Saturating progress counter; flags expiry once TIMEOUT_CYCLES enabled
// cycles pass without a restart.
module stb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Only meaningful while counting; a paused counter never aborts.
  assign expired = enable && (cnt_q == LIMIT);

endmodule

// File: rtl/fp_op_issuer.sv
// Issues operand pairs to a stb/ack FP unit, collects the result into a
// one-deep slot for the consumer and aborts stalled transfers.
module fp_op_issuer
  import fp_stream_pkg::*;
#(
  parameter int unsigned DATA_W         = DEFAULT_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] input_a,
  output logic [DATA_W-1:0] input_b,
  output logic              input_a_stb,
  output logic              input_b_stb,
  input  logic              input_a_ack,
  input  logic              input_b_ack,
  input  logic [DATA_W-1:0] output_z,
  input  logic              output_z_stb,
  output logic              output_z_ack,
  output logic [DATA_W-1:0] res_data,
  output logic              res_valid,
  input  logic              res_ready,
  input  logic              err_clr,
  output logic              err_timeout,
  output logic [CNT_W-1:0]  op_count
);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] input_a_q, input_a_d;
  logic [DATA_W-1:0] input_b_q, input_b_d;
  logic              a_stb_q, a_stb_d;
  logic              b_stb_q, b_stb_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              res_valid_q, res_valid_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  op_count_q, op_count_d;

  logic a_x, b_x, z_x;
  logic err_set;
  logic wd_restart, wd_enable, wd_expired;

  assign in_ready     = (state_q == ST_IDLE);
  assign output_z_ack = (state_q == ST_WAIT_Z) && !res_valid_q;

  assign a_x = xfer(a_stb_q, input_a_ack);
  assign b_x = xfer(b_stb_q, input_b_ack);
  assign z_x = xfer(output_z_stb, output_z_ack);

  always_comb begin
    state_d     = state_q;
    input_a_d   = input_a_q;
    input_b_d   = input_b_q;
    a_stb_d     = a_stb_q;
    b_stb_d     = b_stb_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
    op_count_d  = op_count_q;
    err_set     = 1'b0;

    // Drain and capture never coincide: capture requires an empty slot.
    if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          input_a_d = in_a;
          input_b_d = in_b;
          a_stb_d   = 1'b1;
          b_stb_d   = 1'b1;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        if (a_x) a_stb_d = 1'b0;
        if (b_x) b_stb_d = 1'b0;
        if (!a_stb_d && !b_stb_d) begin
          state_d = ST_WAIT_Z;
        end else if (wd_expired && !a_x && !b_x) begin
          a_stb_d = 1'b0;
          b_stb_d = 1'b0;
          state_d = ST_IDLE;
          err_set = 1'b1;
        end
      end
      ST_WAIT_Z: begin
        if (z_x) begin
          res_data_d  = output_z;
          res_valid_d = 1'b1;
          op_count_d  = op_count_q + CNT_W'(1);
          state_d     = ST_IDLE;
        end else if (wd_expired) begin
          state_d = ST_IDLE;
          err_set = 1'b1;
        end
      end
      default: begin
        a_stb_d = 1'b0;
        b_stb_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    // A fresh timeout outranks a simultaneous clear.
    err_d = err_set || (err_q && !err_clr);
  end

  assign wd_restart = (state_d != state_q) || a_x || b_x || z_x;
  assign wd_enable  = (state_q == ST_SEND) || ((state_q == ST_WAIT_Z) && !res_valid_q);

  stb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(wd_restart),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      input_a_q   <= '0;
      input_b_q   <= '0;
      a_stb_q     <= 1'b0;
      b_stb_q     <= 1'b0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      input_a_q   <= input_a_d;
      input_b_q   <= input_b_d;
      a_stb_q     <= a_stb_d;
      b_stb_q     <= b_stb_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      err_q       <= err_d;
      op_count_q  <= op_count_d;
    end
  end

  assign input_a     = input_a_q;
  assign input_b     = input_b_q;
  assign input_a_stb = a_stb_q;
  assign input_b_stb = b_stb_q;
  assign res_data    = res_data_q;
  assign res_valid   = res_valid_q;
  assign err_timeout = err_q;
  assign op_count    = op_count_q;

endmodule
